module_captura_numero: RTL and testbench
========================================

Name: module_captura_numero

Overview:
- Successor to the single-key keypad decoder. Captures a multi-digit decimal operand from a 4x4 keypad.
- Decodes each key event, edits the entry (digit / backspace / clear / enter), and keeps the entry as both BCD and binary.
- Presents the finished operand to the multiplier datapath with a valid/ack handshake. One instance per operand.

Parameters:
- NUM_DIGITS, 3, maximum number of decimal digits per operand (>=1).
- OUT_W, 10, binary output width; must satisfy 2^OUT_W > 10^NUM_DIGITS - 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- dato_listo_i  in  1  one-cycle strobe: a debounced key press is present on codc/codf.
- dato_codc_i  in  2  column code of pressed key.
- dato_codf_i  in  2  row code of pressed key.
- ack_i  in  1  consumer accepted the operand.
- numero_o  out  OUT_W  binary value of the current entry.
- bcd_o  out  4*NUM_DIGITS  BCD entry; digit 0 (least significant) in bits [3:0].
- num_digitos_o  out  $clog2(NUM_DIGITS+1)  number of digits entered.
- valido_o  out  1  operand complete, held until ack.
- error_o  out  1  one-cycle pulse on a rejected key.
- tecla_o  out  4  last decoded key value; 15 = non-digit or none.

Behaviour:
- Reset (async, rst=0): state IDLE; bcd=0; count=0; valido_o=0; error_o=0; tecla_o=15. numero_o therefore reads 0.
- Key position: pos = {codc, codf}, sampled only when dato_listo_i=1.
- Digit map: 0->1, 1->4, 2->7, 4->2, 5->5, 6->8, 8->3, 9->6, 10->9, 7->0.
- Command keys: pos 3 = CLEAR; pos 11 = ENTER; pos 12 = BACKSPACE.
- pos 13, 14, 15 are invalid keys.
- tecla_o updates on every event: decoded digit, or 15 for any non-digit.
- States:
  - IDLE: count=0.
  - CAPTURA: 0<count<=NUM_DIGITS.
  - LISTO: valido_o=1.
- All register updates occur on the clk edge that samples the event. Outputs reflect the event one cycle after the strobe cycle.
- Digit in IDLE/CAPTURA, count<NUM_DIGITS:
  - bcd shifts left one digit; new digit enters digit 0.
  - count+1; state CAPTURA.
- Digit when count==NUM_DIGITS: entry unchanged; error_o pulses.
- BACKSPACE in CAPTURA: bcd shifts right one digit, zero fill; count-1. State goes to IDLE if count reaches 0.
- BACKSPACE in IDLE: error_o pulses, nothing else changes.
- CLEAR in any state: bcd=0, count=0, valido_o=0, state IDLE, no error. This includes LISTO, which aborts the pending operand.
- ENTER in CAPTURA: state LISTO, valido_o=1.
- ENTER in IDLE: error_o pulses, stays IDLE.
- Invalid key in any state: error_o pulses; entry and state unchanged.
- LISTO:
  - digit, BACKSPACE, ENTER, or invalid key -> error_o pulse, entry frozen.
  - ack_i=1 -> bcd=0, count=0, valido_o=0, state IDLE on the next edge.
  - ack_i with valido_o=0 is ignored.
- Simultaneous ack_i and dato_listo_i in LISTO: ack wins. Key discarded without error; tecla_o still updates.
- numero_o is combinational from the bcd registers: sum of digit_i*10^i, truncated to OUT_W. It is always consistent with bcd_o and has no extra latency.
- bcd_o and numero_o stay stable while valido_o=1.
- error_o is high for exactly one cycle per rejected event and never stays high across two strobes.
- rst asserted mid-entry: immediate return to reset values, no partial operand retained.
- dato_listo_i held high for N cycles counts as N events. The upstream scanner guarantees single-cycle strobes.

Test Plan:
- Reset, then keys pos 0, 4, 8 (1, 2, 3) and ENTER -> bcd_o=0x123, numero_o=123, num_digitos_o=3, valido_o=1; ack_i -> all zero, IDLE.
- Keys 9, 9, 9, then 5 (NUM_DIGITS=3) -> fourth key gives error_o one-cycle pulse; numero_o stays 999 and fits OUT_W=10.
- Keys 7, 8, BACKSPACE, 0 (pos 2, 6, 12, 7) -> bcd_o=0x070, numero_o=70, count=2.
- ENTER in IDLE, and key pos 14 mid-entry -> error_o pulse each time; tecla_o=15; state and value unchanged.
- In LISTO with operand 45, same-cycle dato_listo_i (digit 6) and ack_i -> IDLE, numero_o=0, error_o=0, tecla_o=6.
- Enter 5, 6, then CLEAR -> 0, IDLE. Separately, enter 5, 6, then drop rst for one cycle -> 0, IDLE, and tecla_o=15 after reset.

Source files
------------

// File: rtl/module_captura_numero_if.sv
// Keypad-event, operand and handshake bundle between the keypad front end,
// the operand capture block and the multiplier datapath.
interface module_captura_numero_if #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 10
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  logic                    dato_listo_i;
  logic [1:0]              dato_codc_i;
  logic [1:0]              dato_codf_i;
  logic                    ack_i;
  logic [OUT_W-1:0]        numero_o;
  logic [4*NUM_DIGITS-1:0] bcd_o;
  logic [CW-1:0]           num_digitos_o;
  logic                    valido_o;
  logic                    error_o;
  logic [3:0]              tecla_o;

  // Producer side: keypad scanner plus the operand consumer.
  modport master (
    output dato_listo_i, dato_codc_i, dato_codf_i, ack_i,
    input  numero_o, bcd_o, num_digitos_o, valido_o, error_o, tecla_o
  );

  // Capture block side.
  modport slave (
    input  dato_listo_i, dato_codc_i, dato_codf_i, ack_i,
    output numero_o, bcd_o, num_digitos_o, valido_o, error_o, tecla_o
  );
endinterface

// File: rtl/module_captura_numero.sv
// Multi-digit decimal operand capture from a 4x4 keypad. Keeps the entry in
// BCD, exposes its binary value combinationally, and holds the finished
// operand under a valid/ack handshake.
module module_captura_numero #(
  parameter int NUM_DIGITS = 3,
  parameter int OUT_W      = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  module_captura_numero_if.slave       bus
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  localparam logic [3:0] POS_CLEAR = 4'd3;
  localparam logic [3:0] POS_ENTER = 4'd11;
  localparam logic [3:0] POS_BKSP  = 4'd12;
  localparam logic [3:0] NO_KEY    = 4'd15;

  typedef enum logic [1:0] {IDLE, CAPTURA, LISTO} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           error_q, error_d;
  logic [3:0]     tecla_q, tecla_d;

  logic [3:0]     pos;
  logic           es_digito;
  logic [3:0]     digito;

  assign pos = {bus.dato_codc_i, bus.dato_codf_i};

  // Keypad position to digit; 15 marks any non-digit position.
  always_comb begin
    es_digito = 1'b1;
    digito    = NO_KEY;
    case (pos)
      4'd0:    digito = 4'd1;
      4'd1:    digito = 4'd4;
      4'd2:    digito = 4'd7;
      4'd4:    digito = 4'd2;
      4'd5:    digito = 4'd5;
      4'd6:    digito = 4'd8;
      4'd8:    digito = 4'd3;
      4'd9:    digito = 4'd6;
      4'd10:   digito = 4'd9;
      4'd7:    digito = 4'd0;
      default: es_digito = 1'b0;
    endcase
  end

  // Edit the entry; a same-cycle ack in LISTO takes priority over any key.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    error_d = 1'b0;
    tecla_d = tecla_q;
    if (bus.dato_listo_i) tecla_d = digito;
    if (state_q == LISTO && bus.ack_i) begin
      state_d = IDLE;
      bcd_d   = '0;
      cnt_d   = '0;
    end else if (bus.dato_listo_i) begin
      if (pos == POS_CLEAR) begin
        state_d = IDLE;
        bcd_d   = '0;
        cnt_d   = '0;
      end else if (es_digito) begin
        if (state_q != LISTO && cnt_q < CW'(NUM_DIGITS)) begin
          bcd_d   = (bcd_q << 4) | BW'(digito);
          cnt_d   = cnt_q + 1'b1;
          state_d = CAPTURA;
        end else begin
          error_d = 1'b1;
        end
      end else if (pos == POS_BKSP) begin
        if (state_q == CAPTURA) begin
          bcd_d = bcd_q >> 4;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = IDLE;
        end else begin
          error_d = 1'b1;
        end
      end else if (pos == POS_ENTER) begin
        if (state_q == CAPTURA) state_d = LISTO;
        else                    error_d = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      tecla_q <= NO_KEY;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      tecla_q <= tecla_d;
    end
  end

  // BCD to binary by Horner's rule, most significant digit first.
  logic [OUT_W-1:0] acc;
  always_comb begin
    acc = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      acc = (acc << 3) + (acc << 1) + OUT_W'(bcd_q[4*i +: 4]);
  end

  assign bus.numero_o      = acc;
  assign bus.bcd_o         = bcd_q;
  assign bus.num_digitos_o = cnt_q;
  assign bus.valido_o      = (state_q == LISTO);
  assign bus.error_o       = error_q;
  assign bus.tecla_o       = tecla_q;
endmodule

// File: tb/tb_module_captura_numero.sv
// Directed bench for the keypad operand capture block.
module tb_module_captura_numero;
  localparam int ND = 3;
  localparam int OW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  module_captura_numero_if #(.NUM_DIGITS(ND), .OUT_W(OW)) bus ();

  module_captura_numero #(.NUM_DIGITS(ND), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; on return we sit at the negedge after the sampling edge.
  task automatic key(input logic [3:0] pos, input logic ack = 1'b0);
    @(negedge clk);
    bus.dato_listo_i = 1'b1;
    bus.dato_codc_i  = pos[3:2];
    bus.dato_codf_i  = pos[1:0];
    bus.ack_i        = ack;
    @(negedge clk);
    bus.dato_listo_i = 1'b0;
    bus.ack_i        = 1'b0;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    bus.dato_listo_i = 1'b0;
    bus.dato_codc_i  = 2'd0;
    bus.dato_codf_i  = 2'd0;
    bus.ack_i        = 1'b0;
    #12;
    chk("rst_numero", 32'(bus.numero_o), 0);
    chk("rst_bcd", 32'(bus.bcd_o), 0);
    chk("rst_cnt", 32'(bus.num_digitos_o), 0);
    chk("rst_valido", 32'(bus.valido_o), 0);
    chk("rst_error", 32'(bus.error_o), 0);
    chk("rst_tecla", 32'(bus.tecla_o), 15);
    @(negedge clk);
    rst = 1'b1;

    // 1,2,3 ENTER, then ack
    key(4'd0); key(4'd4); key(4'd8);
    chk("t1_bcd", 32'(bus.bcd_o), 32'h123);
    chk("t1_numero", 32'(bus.numero_o), 123);
    chk("t1_cnt", 32'(bus.num_digitos_o), 3);
    chk("t1_tecla", 32'(bus.tecla_o), 3);
    chk("t1_valido_pre", 32'(bus.valido_o), 0);
    key(4'd11);
    chk("t1_valido", 32'(bus.valido_o), 1);
    chk("t1_err_enter", 32'(bus.error_o), 0);
    key(4'd0);
    chk("t1_listo_digit_err", 32'(bus.error_o), 1);
    chk("t1_listo_frozen", 32'(bus.bcd_o), 32'h123);
    chk("t1_listo_valido", 32'(bus.valido_o), 1);
    idle_cycle();
    chk("t1_err_one_cycle", 32'(bus.error_o), 0);
    ack_pulse();
    chk("t1_ack_valido", 32'(bus.valido_o), 0);
    chk("t1_ack_numero", 32'(bus.numero_o), 0);
    chk("t1_ack_cnt", 32'(bus.num_digitos_o), 0);

    // 9,9,9 then 5 overflows
    key(4'd10); key(4'd10); key(4'd10);
    chk("t2_999", 32'(bus.numero_o), 999);
    chk("t2_err_pre", 32'(bus.error_o), 0);
    key(4'd5);
    chk("t2_err", 32'(bus.error_o), 1);
    chk("t2_numero", 32'(bus.numero_o), 999);
    chk("t2_bcd", 32'(bus.bcd_o), 32'h999);
    chk("t2_tecla", 32'(bus.tecla_o), 5);
    idle_cycle();
    chk("t2_err_drop", 32'(bus.error_o), 0);
    key(4'd3);
    chk("t2_clear", 32'(bus.numero_o), 0);
    chk("t2_clear_cnt", 32'(bus.num_digitos_o), 0);

    // 7,8,BACKSPACE,0
    key(4'd2); key(4'd6); key(4'd12);
    chk("t3_bksp_bcd", 32'(bus.bcd_o), 32'h7);
    chk("t3_bksp_tecla", 32'(bus.tecla_o), 15);
    key(4'd7);
    chk("t3_bcd", 32'(bus.bcd_o), 32'h070);
    chk("t3_numero", 32'(bus.numero_o), 70);
    chk("t3_cnt", 32'(bus.num_digitos_o), 2);
    chk("t3_tecla", 32'(bus.tecla_o), 0);

    // invalid key mid-entry
    key(4'd14);
    chk("t4_inv_err", 32'(bus.error_o), 1);
    chk("t4_inv_tecla", 32'(bus.tecla_o), 15);
    chk("t4_inv_bcd", 32'(bus.bcd_o), 32'h070);
    chk("t4_inv_cnt", 32'(bus.num_digitos_o), 2);
    key(4'd3);
    chk("t4_clear_err", 32'(bus.error_o), 0);
    // ENTER and BACKSPACE in IDLE
    key(4'd11);
    chk("t4_enter_idle_err", 32'(bus.error_o), 1);
    chk("t4_enter_idle_valido", 32'(bus.valido_o), 0);
    key(4'd12);
    chk("t4_bksp_idle_err", 32'(bus.error_o), 1);
    chk("t4_bksp_idle_cnt", 32'(bus.num_digitos_o), 0);
    // backspace to empty returns to IDLE: ENTER must then be rejected
    key(4'd0); key(4'd12);
    chk("t4_bk_empty_cnt", 32'(bus.num_digitos_o), 0);
    key(4'd11);
    chk("t4_bk_empty_enter_err", 32'(bus.error_o), 1);
    chk("t4_bk_empty_valido", 32'(bus.valido_o), 0);

    // operand 45 in LISTO, same-cycle digit 6 and ack
    key(4'd1); key(4'd5); key(4'd11);
    chk("t5_numero", 32'(bus.numero_o), 45);
    chk("t5_valido", 32'(bus.valido_o), 1);
    key(4'd9, 1'b1);
    chk("t5_sim_valido", 32'(bus.valido_o), 0);
    chk("t5_sim_numero", 32'(bus.numero_o), 0);
    chk("t5_sim_err", 32'(bus.error_o), 0);
    chk("t5_sim_tecla", 32'(bus.tecla_o), 6);
    chk("t5_sim_cnt", 32'(bus.num_digitos_o), 0);

    // 5,6 CLEAR
    key(4'd5); key(4'd9);
    chk("t6_56", 32'(bus.numero_o), 56);
    key(4'd3);
    chk("t6_clear_numero", 32'(bus.numero_o), 0);
    chk("t6_clear_cnt", 32'(bus.num_digitos_o), 0);
    // 5,6 then async reset pulse
    key(4'd5); key(4'd9);
    chk("t6_56b", 32'(bus.numero_o), 56);
    rst = 1'b0;
    #1;
    chk("t6_rst_numero", 32'(bus.numero_o), 0);
    chk("t6_rst_cnt", 32'(bus.num_digitos_o), 0);
    chk("t6_rst_tecla", 32'(bus.tecla_o), 15);
    @(negedge clk);
    rst = 1'b1;
    key(4'd11);
    chk("t6_post_rst_enter_err", 32'(bus.error_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
